// File: rtl/mem_to_axi_lite.sv
// mem_to_axi_lite: bridges a single-beat req/gnt/rvalid memory port onto an
// AXI4-Lite master port, with one transaction outstanding at a time.

package mem_to_axi_lite_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [2:0]           prot;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_lite_resp_t;

endpackage

module mem_to_axi_lite #(
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter type         axi_lite_req_t  = mem_to_axi_lite_pkg::axi_lite_req_t,
  parameter type         axi_lite_resp_t = mem_to_axi_lite_pkg::axi_lite_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output logic                   busy_o,
  output axi_lite_req_t          axi_lite_req_o,
  input  axi_lite_resp_t         axi_lite_resp_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    RD_AR,
    WAIT_R
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] strb_q;
  logic                   aw_valid_q;
  logic                   w_valid_q;
  logic                   ar_valid_q;
  logic                   b_ready_q;
  logic                   r_ready_q;
  logic                   rvalid_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   err_q;

  logic aw_done;
  logic w_done;
  logic unused_resp_lsbs;

  // A write channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = ~aw_valid_q | axi_lite_resp_i.aw_ready;
  assign w_done  = ~w_valid_q  | axi_lite_resp_i.w_ready;

  assign unused_resp_lsbs = ^{axi_lite_resp_i.b.resp[0], axi_lite_resp_i.r.resp[0]};

  assign mem_gnt_o    = mem_req_i & rst_ni & (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rdata_q;
  assign mem_err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            strb_q  <= mem_strb_i;
            if (mem_we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WR;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RD_AR;
            end
          end
        end

        // AW and W complete independently; B is only accepted after both.
        WR: begin
          if (aw_valid_q && axi_lite_resp_i.aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && axi_lite_resp_i.w_ready) w_valid_q <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= WAIT_B;
          end
        end

        WAIT_B: begin
          if (axi_lite_resp_i.b_valid) begin
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= axi_lite_resp_i.b.resp[1];
            state_q   <= IDLE;
          end
        end

        RD_AR: begin
          if (axi_lite_resp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= WAIT_R;
          end
        end

        WAIT_R: begin
          if (axi_lite_resp_i.r_valid) begin
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= axi_lite_resp_i.r.data;
            err_q     <= axi_lite_resp_i.r.resp[1];
            state_q   <= IDLE;
          end
        end

        default: begin
          aw_valid_q <= 1'b0;
          w_valid_q  <= 1'b0;
          ar_valid_q <= 1'b0;
          b_ready_q  <= 1'b0;
          r_ready_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Every request-side field comes straight from a register.
  always_comb begin
    axi_lite_req_o          = '0;
    axi_lite_req_o.aw.addr  = addr_q;
    axi_lite_req_o.aw.prot  = 3'b000;
    axi_lite_req_o.aw_valid = aw_valid_q;
    axi_lite_req_o.w.data   = wdata_q;
    axi_lite_req_o.w.strb   = strb_q;
    axi_lite_req_o.w_valid  = w_valid_q;
    axi_lite_req_o.b_ready  = b_ready_q;
    axi_lite_req_o.ar.addr  = addr_q;
    axi_lite_req_o.ar.prot  = 3'b000;
    axi_lite_req_o.ar_valid = ar_valid_q;
    axi_lite_req_o.r_ready  = r_ready_q;
  end

endmodule

// File: tb/tb_mem_to_axi_lite.sv
// tb_mem_to_axi_lite: directed requests against a small AXI-Lite slave model,
// with completions checked by a queue-based scoreboard.

module tb_mem_to_axi_lite;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;

  mem_to_axi_lite_pkg::axi_lite_req_t  axi_req;
  mem_to_axi_lite_pkg::axi_lite_resp_t axi_resp;

  mem_to_axi_lite dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_i      (mem_req),
    .mem_gnt_o      (mem_gnt),
    .mem_addr_i     (mem_addr),
    .mem_we_i       (mem_we),
    .mem_wdata_i    (mem_wdata),
    .mem_strb_i     (mem_strb),
    .mem_rvalid_o   (mem_rvalid),
    .mem_rdata_o    (mem_rdata),
    .mem_err_o      (mem_err),
    .busy_o         (busy),
    .axi_lite_req_o (axi_req),
    .axi_lite_resp_i(axi_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv_cyc = -1;
  int rv_count = 0;
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model knobs
  logic [31:0] slv_rdata = 32'h0;
  logic [1:0]  slv_resp = 2'b00;
  int          aw_wait = 0;
  bit          slv_no_r = 1'b0;
  bit          stray = 1'b0;

  bit aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w, b_pend, r_pend;
  int aw_cnt;

  initial axi_resp = '0;

  // Slave acts on handshakes seen at the previous negedge, which the DUT
  // completed at the rising edge in between.
  always @(negedge clk) begin
    if (!rst_n) begin
      {aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w, b_pend, r_pend} = '0;
      aw_cnt = 0;
      axi_resp = '0;
    end else begin
      if (b_hs) b_pend = 1'b0;
      if (r_hs) r_pend = 1'b0;
      if (aw_hs) begin got_aw = 1'b1; aw_cnt = 0; end
      if (w_hs) got_w = 1'b1;
      if (got_aw && got_w) begin
        b_pend = 1'b1;
        axi_resp.b.resp = slv_resp;
        got_aw = 1'b0;
        got_w = 1'b0;
      end
      if (ar_hs && !slv_no_r) begin
        r_pend = 1'b1;
        axi_resp.r.data = slv_rdata;
        axi_resp.r.resp = slv_resp;
      end
      axi_resp.aw_ready = axi_req.aw_valid && (aw_cnt >= aw_wait);
      if (axi_req.aw_valid && !axi_resp.aw_ready) aw_cnt++;
      axi_resp.w_ready  = 1'b1;
      axi_resp.ar_ready = 1'b1;
      axi_resp.b_valid  = b_pend | stray;
      axi_resp.r_valid  = r_pend | stray;
      aw_hs = axi_req.aw_valid & axi_resp.aw_ready;
      w_hs  = axi_req.w_valid & axi_resp.w_ready;
      ar_hs = axi_req.ar_valid & axi_resp.ar_ready;
      b_hs  = axi_resp.b_valid & axi_req.b_ready;
      r_hs  = axi_resp.r_valid & axi_req.r_ready;
    end
  end

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mem_rvalid) begin
        total++;
        rv_cyc = cyc;
        rv_count++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_rvalid got rdata=%h err=%b want no completion", mem_rdata, mem_err);
        end else begin
          e = exp_q.pop_front();
          if ({mem_rdata, mem_err} !== e) begin
            bad++;
            $display("[TB] FAIL scoreboard got rdata=%h err=%b want rdata=%h err=%b",
                     mem_rdata, mem_err, e[32:1], e[0]);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Present a request and hold it until granted; optionally queue the expected completion.
  task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                               input logic [3:0] st, input bit push, input logic [31:0] exp_rd,
                               input logic exp_e, output int gnt_cyc);
    int n = 0;
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = a;
    mem_we = we;
    mem_wdata = wd;
    mem_strb = st;
    #1;
    while (!mem_gnt && n < 50) begin
      checkOutput("busy_while_waiting", {31'b0, busy}, 32'd1);
      @(negedge clk);
      #1;
      n++;
    end
    gnt_cyc = -1;
    if (!mem_gnt) begin
      total++;
      bad++;
      $display("[TB] FAIL gnt_timeout got gnt=0 want gnt=1 within 50 cycles");
    end else begin
      gnt_cyc = cyc;
      if (push) exp_q.push_back({exp_rd, exp_e});
    end
    @(posedge clk);
  endtask

  task automatic dropReq();
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] handshakeBits();
    return {27'b0, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready};
  endfunction

  initial begin
    int g;
    int g0, g1, g2, g3;
    int saved_rv;

    rst_n = 1'b0;
    mem_req = 1'b1;
    mem_addr = 32'h0;
    mem_we = 1'b0;
    mem_wdata = 32'h0;
    mem_strb = 4'h0;

    // Reset state, with a request already pending
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_gnt", {31'b0, mem_gnt}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_rvalid", {31'b0, mem_rvalid}, 32'd0);
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    checkOutput("reset_err", {31'b0, mem_err}, 32'd0);
    checkOutput("reset_axi", handshakeBits(), 32'd0);
    mem_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read with an always-ready slave
    $display("[TB] read, ready slave");
    slv_rdata = 32'hDEAD_BEEF;
    applyStimulus(32'h4000_0004, 1'b0, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, g);
    dropReq();
    #1;
    checkOutput("rd_c1_ar_valid", {31'b0, axi_req.ar_valid}, 32'd1);
    checkOutput("rd_c1_ar_addr", axi_req.ar.addr, 32'h4000_0004);
    checkOutput("rd_c1_ar_prot", {29'b0, axi_req.ar.prot}, 32'd0);
    checkOutput("rd_c1_r_ready", {31'b0, axi_req.r_ready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rd_c2_r_ready", {31'b0, axi_req.r_ready}, 32'd1);
    checkOutput("rd_c2_ar_valid", {31'b0, axi_req.ar_valid}, 32'd0);
    @(negedge clk);
    #2;
    checkOutput("rd_latency", 32'(rv_cyc), 32'(g + 3));
    waitDone();

    // Write with AW ready held off, W ready immediately
    $display("[TB] write, skewed readiness");
    aw_wait = 2;
    applyStimulus(32'h4000_0010, 1'b1, 32'h0000_0001, 4'hF, 1'b1, 32'h0, 1'b0, g);
    dropReq();
    #1;
    checkOutput("wr_c1_valids", {30'b0, axi_req.aw_valid, axi_req.w_valid}, 32'd3);
    checkOutput("wr_c1_wdata", axi_req.w.data, 32'h0000_0001);
    checkOutput("wr_c1_strb", {28'b0, axi_req.w.strb}, 32'hF);
    checkOutput("wr_c1_aw_prot", {29'b0, axi_req.aw.prot}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_c2_valids", {30'b0, axi_req.aw_valid, axi_req.w_valid}, 32'd2);
    checkOutput("wr_c2_aw_addr", axi_req.aw.addr, 32'h4000_0010);
    checkOutput("wr_c2_b_ready", {31'b0, axi_req.b_ready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_c3_aw_valid", {31'b0, axi_req.aw_valid}, 32'd1);
    checkOutput("wr_c3_aw_addr", axi_req.aw.addr, 32'h4000_0010);
    checkOutput("wr_c3_b_ready", {31'b0, axi_req.b_ready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_c4_aw_valid", {31'b0, axi_req.aw_valid}, 32'd0);
    checkOutput("wr_c4_b_ready", {31'b0, axi_req.b_ready}, 32'd1);
    @(negedge clk);
    #2;
    checkOutput("wr_latency", 32'(rv_cyc), 32'(g + 5));
    aw_wait = 0;
    waitDone();

    // DECERR read, then an OKAY write clears the error
    $display("[TB] error response");
    slv_resp = 2'b11;
    slv_rdata = 32'h0;
    applyStimulus(32'h5000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, g);
    dropReq();
    waitDone();
    @(negedge clk);
    #1;
    checkOutput("err_held", {31'b0, mem_err}, 32'd1);
    slv_resp = 2'b00;
    applyStimulus(32'h4000_0020, 1'b1, 32'hA5A5_A5A5, 4'h3, 1'b1, 32'h0, 1'b0, g);
    dropReq();
    #1;
    checkOutput("err_wr_strb", {28'b0, axi_req.w.strb}, 32'h3);
    waitDone();

    // Stray B/R valids while idle
    $display("[TB] stray responses");
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stray_readies", {30'b0, axi_req.b_ready, axi_req.r_ready}, 32'd0);
      checkOutput("stray_busy", {31'b0, busy}, 32'd0);
    end
    stray = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back alternating read/write with request held high
    $display("[TB] back-to-back");
    slv_rdata = 32'h1234_5678;
    applyStimulus(32'h4000_0100, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0, g0);
    applyStimulus(32'h4000_0104, 1'b1, 32'h0BAD_F00D, 4'hC, 1'b1, 32'h0, 1'b0, g1);
    applyStimulus(32'h4000_0108, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0, g2);
    applyStimulus(32'h4000_010C, 1'b1, 32'h0000_00FF, 4'h1, 1'b1, 32'h0, 1'b0, g3);
    dropReq();
    checkOutput("b2b_gap1", 32'(g1 - g0), 32'd3);
    checkOutput("b2b_gap2", 32'(g2 - g1), 32'd3);
    checkOutput("b2b_gap3", 32'(g3 - g2), 32'd3);
    waitDone();

    // Reset while waiting for R
    $display("[TB] reset mid-read");
    slv_no_r = 1'b1;
    saved_rv = rv_count;
    applyStimulus(32'h4000_0200, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, g);
    @(negedge clk);
    #1;
    checkOutput("rst_c1_ar_valid", {31'b0, axi_req.ar_valid}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rst_c2_r_ready", {31'b0, axi_req.r_ready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_c3_axi", handshakeBits(), 32'd0);
    checkOutput("rst_c3_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_c3_gnt", {31'b0, mem_gnt}, 32'd0);
    rst_n = 1'b1;
    mem_req = 1'b0;
    slv_no_r = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_no_rvalid", 32'(rv_count), 32'(saved_rv));

    slv_rdata = 32'hCAFE_F00D;
    applyStimulus(32'h4000_0008, 1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, g);
    dropReq();
    waitDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_to_axi_lite.md
# mem_to_axi_lite

Memory-style request master to AXI4-Lite master bridge: the initiator counterpart of the AXI-Lite register responders and `axi2mem` slaves in the MemPool system. It accepts single-beat requests on a req/gnt/rvalid interface (e.g. from a debug/boot sequencer or host-side agent) and issues them as AXI4-Lite transactions toward `ctrl_registers` or any AXI-Lite slave. One transaction is outstanding at a time; errors from the slave are returned alongside the response.

## Interface
- `AddrWidth`, 32, AXI-Lite and memory address width
- `DataWidth`, 32, data width; strobe width `DataWidth/8`
- `axi_lite_req_t`, `axi_lite_slv_req_t`, AXI-Lite request struct type
- `axi_lite_resp_t`, `axi_lite_slv_resp_t`, AXI-Lite response struct type
- `clk_i`  in  1  clock, all logic rising-edge
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low
- `mem_req_i`  in  1  request valid
- `mem_gnt_o`  out  1  request accepted this cycle
- `mem_addr_i`  in  AddrWidth  byte address
- `mem_we_i`  in  1  1 = write, 0 = read
- `mem_wdata_i`  in  DataWidth  write data
- `mem_strb_i`  in  DataWidth/8  write byte enables
- `mem_rvalid_o`  out  1  one-cycle completion pulse (reads and writes)
- `mem_rdata_o`  out  DataWidth  read data, valid with `mem_rvalid_o`
- `mem_err_o`  out  1  slave returned SLVERR/DECERR, valid with `mem_rvalid_o`
- `busy_o`  out  1  FSM not in IDLE
- `axi_lite_req_o`  out  struct  AW/W/B/AR/R request channels
- `axi_lite_resp_i`  in  struct  AW/W/B/AR/R response channels

## Operation
- FSM states: IDLE, WR (AW/W pending), WAIT_B, RD_AR, WAIT_R.
- IDLE: `mem_gnt_o = mem_req_i & rst_ni`. On grant, latch addr, we, wdata, strb; go to WR if we, else RD_AR.
- WR: `aw_valid` and `w_valid` both high on entry; each drops independently on its own handshake and stays low. When both done (including same cycle) -> WAIT_B.
- WAIT_B: `b_ready`=1. On B handshake: capture `err = b.resp[1]`, rdata captured as 0, -> IDLE.
- RD_AR: `ar_valid`=1 until `ar_ready` -> WAIT_R.
- WAIT_R: `r_ready`=1. On R handshake capture `r.data`, `err = r.resp[1]`, -> IDLE.
- `b_ready`/`r_ready` low in all other states; no response accepted before its request handshake.
- AW/AR prot = 3'b000; addresses and strobes forwarded unmodified; w.strb = latched strb.
- Valids, once asserted, held with stable payload until handshake (AXI rule).
- `mem_gnt_o` may assert in the cycle `mem_rvalid_o` pulses (FSM already back in IDLE).
- Unexpected B/R valid outside wait states: ignored (ready low), no state change.

## Timing
- Reset (rst_ni low at a rising edge): FSM -> IDLE, all AXI valids/readies 0, `mem_rvalid_o`=0, `mem_err_o`=0, `mem_rdata_o`=0, `busy_o`=0; `mem_gnt_o`=0 while rst_ni low.
- Reset mid-transaction: in-flight transaction abandoned, valids drop at that edge, no `mem_rvalid_o` produced.
- `mem_rvalid_o`, `mem_rdata_o`, `mem_err_o` registered: asserted the cycle after the B/R handshake, for exactly one cycle; rdata/err hold value until next completion.
- Minimum latency with ready-always slave: grant cycle 0, AW/W or AR handshake cycle 1, B/R handshake cycle 2, `mem_rvalid_o` cycle 3. Max throughput one transaction per 3 cycles.
- No combinational path from `axi_lite_resp_i` to `axi_lite_req_o` or to mem outputs, except none; `mem_gnt_o` depends only on `mem_req_i`, state, rst_ni.

## Test plan
- Read, ready-always slave: req addr 0x4000_0004, we=0; slave returns 0xDEAD_BEEF OKAY -> gnt cycle 0, ar_valid cycle 1, rvalid cycle 3 with rdata 0xDEAD_BEEF, err 0.
- Write with skewed readiness: addr 0x4000_0010, wdata 0x0000_0001, strb 0xF; aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after cycle 1, aw_valid held stable 3 cycles, b_ready only after both, one rvalid pulse, err 0.
- Error: read to unmapped address, slave responds DECERR (2'b11) -> rvalid with err 1; following write with OKAY -> err 0.
- Back-to-back: req held high for 4 transactions alternating rd/wr -> gnts at cycles 0,3,6,9; each rvalid one cycle, in order; busy_o low only in grant cycles.
- Stray response: b_valid/r_valid driven in IDLE -> readies stay 0, no rvalid, no state change.
- Reset mid-read: assert rst_ni low while in WAIT_R -> next cycle all valids/readies 0, busy_o 0, no rvalid; new request after release completes normally.
